serial_paralelo_lanes: RTL and testbench



---
 rtl/serial_paralelo_lanes_pkg.sv | 15 +
 rtl/serial_paralelo_lanes_lane.sv | 161 ++++++++++++++++
 rtl/serial_paralelo_lanes.sv | 40 ++++
 tb/tb_serial_paralelo_lanes.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_lanes_pkg.sv
// Shared definitions for the multi-lane serial-to-parallel receiver:
// lane state encoding and default symbol constants.
package serial_paralelo_lanes_pkg;

  typedef enum logic [1:0] {
    LANE_HUNT   = 2'd0,
    LANE_COUNT  = 2'd1,
    LANE_ACTIVE = 2'd2
  } lane_state_e;

  localparam int         DEF_SYMBOL_W    = 8;
  localparam logic [7:0] DEF_COM_SYMBOL  = 8'hBC;
  localparam logic [7:0] DEF_IDLE_SYMBOL = 8'h7C;

endpackage

// File: rtl/serial_paralelo_lanes_lane.sv
// One receiver lane: sliding COM hunt, COM confirmation count and symbol output.
// Optional loss-of-sync drop back to HUNT when built with LOS_DETECT_EN.
module serial_paralelo_lane
  import serial_paralelo_lanes_pkg::*;
#(
  parameter int                  SYMBOL_W      = DEF_SYMBOL_W,
  parameter logic [SYMBOL_W-1:0] COM_SYMBOL    = SYMBOL_W'(DEF_COM_SYMBOL),
  parameter logic [SYMBOL_W-1:0] IDLE_SYMBOL   = SYMBOL_W'(DEF_IDLE_SYMBOL),
  parameter int                  COM_TO_ACTIVE = 4,
  parameter int                  LOS_LIMIT     = 4
) (
  input  logic                clk_32f,
  input  logic                reset,
  input  logic                serial_i,
  output logic [SYMBOL_W-1:0] data_o,
  output logic                valid_o,
  output logic                active_o,
  output logic                strobe_o
);

  localparam int            BW       = $clog2(SYMBOL_W);
  localparam int            CW       = $clog2(COM_TO_ACTIVE + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SYMBOL_W - 1);
  localparam logic [CW-1:0] COM_LAST = CW'(COM_TO_ACTIVE - 1);

  lane_state_e         state_q, state_d;
  logic [SYMBOL_W-2:0] sr_q, sr_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]       com_cnt_q, com_cnt_d;
  logic [SYMBOL_W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                active_q, active_d;
  logic                strobe_q, strobe_d;

  logic [SYMBOL_W-1:0] sym_next;
  logic                is_com;
  logic                boundary;
  logic                los_drop;

  assign sym_next = {sr_q, serial_i};
  assign sr_d     = sym_next[SYMBOL_W-2:0];
  assign is_com   = (sym_next == COM_SYMBOL);
  assign boundary = (bit_cnt_q == BIT_LAST);

`ifdef LOS_DETECT_EN
  localparam int            LW       = $clog2(LOS_LIMIT + 1);
  localparam logic [LW-1:0] LOS_LAST = LW'(LOS_LIMIT - 1);

  logic [LW-1:0] los_cnt_q, los_cnt_d;
  logic          los_hit;

  assign los_hit  = (sym_next == '0) || (sym_next == '1);
  assign los_drop = (state_q == LANE_ACTIVE) && boundary && los_hit && (los_cnt_q == LOS_LAST);

  always_comb begin
    los_cnt_d = los_cnt_q;
    if (state_q == LANE_ACTIVE && boundary) begin
      los_cnt_d = (los_hit && !los_drop) ? los_cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) los_cnt_q <= '0;
    else       los_cnt_q <= los_cnt_d;
  end
`else
  logic unused_los;
  assign unused_los = (LOS_LIMIT != 0);
  assign los_drop   = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    strobe_d  = 1'b0;

    case (state_q)
      LANE_HUNT: begin
        // Bit-granular alignment: any edge completing a COM defines the phase.
        bit_cnt_d = '0;
        if (is_com) begin
          strobe_d  = 1'b1;
          com_cnt_d = CW'(1);
          if (COM_TO_ACTIVE == 1) begin
            state_d  = LANE_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = LANE_COUNT;
          end
        end
      end
      LANE_COUNT: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (!is_com) begin
            state_d   = LANE_HUNT;
            com_cnt_d = '0;
          end else begin
            com_cnt_d = com_cnt_q + 1'b1;
            if (com_cnt_q == COM_LAST) begin
              state_d  = LANE_ACTIVE;
              active_d = 1'b1;
            end
          end
        end
      end
      LANE_ACTIVE: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (los_drop) begin
            state_d   = LANE_HUNT;
            active_d  = 1'b0;
            valid_d   = 1'b0;
            com_cnt_d = '0;
          end else begin
            data_d  = sym_next;
            valid_d = !is_com && (sym_next != IDLE_SYMBOL);
          end
        end
      end
      default: state_d = LANE_HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours. The shift register
  // is reset too, so a symbol interrupted by reset can never be completed.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= LANE_HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign active_o = active_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/serial_paralelo_lanes.sv
// Multi-lane serial-to-parallel RX front end: NUM_LANES independent lanes.
// Build with LOS_DETECT_EN to enable per-lane loss-of-sync detection.
module serial_paralelo_lanes
  import serial_paralelo_lanes_pkg::*;
#(
  parameter int                  NUM_LANES     = 2,
  parameter int                  SYMBOL_W      = DEF_SYMBOL_W,
  parameter logic [SYMBOL_W-1:0] COM_SYMBOL    = SYMBOL_W'(DEF_COM_SYMBOL),
  parameter logic [SYMBOL_W-1:0] IDLE_SYMBOL   = SYMBOL_W'(DEF_IDLE_SYMBOL),
  parameter int                  COM_TO_ACTIVE = 4,
  parameter int                  LOS_LIMIT     = 4
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  input  logic [NUM_LANES-1:0]          data_serial,
  output logic [NUM_LANES*SYMBOL_W-1:0] data_paralelo,
  output logic [NUM_LANES-1:0]          valid_out,
  output logic [NUM_LANES-1:0]          active,
  output logic [NUM_LANES-1:0]          symbol_strobe
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    serial_paralelo_lane #(
      .SYMBOL_W      (SYMBOL_W),
      .COM_SYMBOL    (COM_SYMBOL),
      .IDLE_SYMBOL   (IDLE_SYMBOL),
      .COM_TO_ACTIVE (COM_TO_ACTIVE),
      .LOS_LIMIT     (LOS_LIMIT)
    ) u_lane (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .serial_i (data_serial[i]),
      .data_o   (data_paralelo[i*SYMBOL_W +: SYMBOL_W]),
      .valid_o  (valid_out[i]),
      .active_o (active[i]),
      .strobe_o (symbol_strobe[i])
    );
  end

endmodule

// File: tb/tb_serial_paralelo_lanes.sv
// Self-checking bench: a 2-lane/8-bit instance and a 4-lane/10-bit instance,
// both compared every edge against a bit-history reference model.
module tb_serial_paralelo_lanes;

  localparam int NEED    = 4;
  localparam int LOS_LIM = 4;

  typedef struct {
    int          mode;    // 0 hunting, 1 confirming, 2 locked
    int          t;
    int          t0;
    int          ncom;
    int          nlos;
    logic [15:0] hist;
    logic [15:0] data;
    logic        valid;
    logic        active;
    logic        strobe;
  } lane_model_t;

  typedef struct {
    logic [7:0]  sym0;
    logic [7:0]  sym1;
    logic [15:0] exp_data;
    logic [1:0]  exp_valid;
    logic [1:0]  exp_active;
  } vec_t;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic [1:0]  data_serial;
  logic [15:0] data_paralelo;
  logic [1:0]  valid_out, active, symbol_strobe;
  logic [3:0]  data_serial4;
  logic [39:0] data_paralelo4;
  logic [3:0]  valid_out4, active4, symbol_strobe4;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_lanes dut (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .data_serial   (data_serial),
    .data_paralelo (data_paralelo),
    .valid_out     (valid_out),
    .active        (active),
    .symbol_strobe (symbol_strobe)
  );

  serial_paralelo_lanes #(
    .NUM_LANES   (4),
    .SYMBOL_W    (10),
    .COM_SYMBOL  (10'h17C),
    .IDLE_SYMBOL (10'h07C)
  ) dut4 (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .data_serial   (data_serial4),
    .data_paralelo (data_paralelo4),
    .valid_out     (valid_out4),
    .active        (active4),
    .symbol_strobe (symbol_strobe4)
  );

  int n_checks = 0;
  int n_errors = 0;

  lane_model_t m2 [2];
  lane_model_t m4 [4];

  // Bit streams: indices 0..1 feed dut lanes, 2..5 feed dut4 lanes.
  bit bits_mem [6][1024];
  int len [6];
  int ecount;
  int first_strobe [2];
  int first_active [2];
  int first_valid  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic lane_model_t model_clear();
    lane_model_t m;
    m.mode = 0; m.t = 0; m.t0 = 0; m.ncom = 0; m.nlos = 0;
    m.hist = '0; m.data = '0; m.valid = 1'b0; m.active = 1'b0; m.strobe = 1'b0;
    return m;
  endfunction

  // Symbol = last w bits received; boundaries are every w edges after the lock edge.
  function automatic lane_model_t model_step(input lane_model_t m_in, input logic b,
                                             input int w, input logic [15:0] com,
                                             input logic [15:0] idle);
    lane_model_t m;
    logic [15:0] mask, sym;
    logic        drop;
    m      = m_in;
    mask   = 16'((32'd1 << w) - 1);
    m.t    = m.t + 1;
    sym    = ((m.hist << 1) | {15'd0, b}) & mask;
    m.hist = sym;
    m.strobe = 1'b0;
    drop   = 1'b0;
    if (m.mode == 0) begin
      if (sym == com) begin
        m.strobe = 1'b1;
        m.t0     = m.t;
        m.ncom   = 1;
        m.mode   = (m.ncom >= NEED) ? 2 : 1;
        m.active = (m.mode == 2);
      end
    end else if ((m.t - m.t0) % w == 0) begin
      m.strobe = 1'b1;
      if (m.mode == 1) begin
        if (sym == com) begin
          m.ncom++;
          if (m.ncom >= NEED) begin
            m.mode = 2; m.active = 1'b1;
          end
        end else begin
          m.mode = 0; m.ncom = 0;
        end
      end else begin
`ifdef LOS_DETECT_EN
        if (sym == 16'd0 || sym == mask) begin
          m.nlos++;
          drop = (m.nlos >= LOS_LIM);
        end else begin
          m.nlos = 0;
        end
`endif
        if (drop) begin
          m.mode = 0; m.active = 1'b0; m.valid = 1'b0; m.nlos = 0; m.ncom = 0;
        end else begin
          m.data  = sym;
          m.valid = (sym != com) && (sym != idle);
        end
      end
    end
    return m;
  endfunction

  task automatic models_reset();
    for (int i = 0; i < 2; i++) m2[i] = model_clear();
    for (int i = 0; i < 4; i++) m4[i] = model_clear();
  endtask

  task automatic step(input logic [1:0] b2, input logic [3:0] b4);
    logic [15:0] ed2;
    logic [1:0]  ev2, ea2, es2;
    logic [39:0] ed4;
    logic [3:0]  ev4, ea4, es4;
    @(negedge clk_32f);
    data_serial  = b2;
    data_serial4 = b4;
    @(posedge clk_32f);
    #1;
    for (int i = 0; i < 2; i++) begin
      m2[i] = model_step(m2[i], b2[i], 8, 16'h00BC, 16'h007C);
      ed2[i*8 +: 8] = m2[i].data[7:0];
      ev2[i] = m2[i].valid; ea2[i] = m2[i].active; es2[i] = m2[i].strobe;
    end
    for (int i = 0; i < 4; i++) begin
      m4[i] = model_step(m4[i], b4[i], 10, 16'h017C, 16'h007C);
      ed4[i*10 +: 10] = m4[i].data[9:0];
      ev4[i] = m4[i].valid; ea4[i] = m4[i].active; es4[i] = m4[i].strobe;
    end
    check("model2", {data_paralelo, valid_out, active, symbol_strobe}, {ed2, ev2, ea2, es2});
    check("model4", {data_paralelo4, valid_out4, active4, symbol_strobe4}, {ed4, ev4, ea4, es4});
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset        = 1'b1;
    data_serial  = '0;
    data_serial4 = '0;
    models_reset();
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic push_bit(input int lane, input bit b);
    bits_mem[lane][len[lane]] = b;
    len[lane]++;
  endtask

  task automatic push_sym(input int lane, input logic [15:0] sym, input int w);
    for (int k = w - 1; k >= 0; k--) push_bit(lane, sym[k]);
  endtask

  task automatic push_zeros(input int lane, input int n);
    for (int k = 0; k < n; k++) push_bit(lane, 1'b0);
  endtask

  task automatic clear_events();
    ecount = 0;
    for (int l = 0; l < 2; l++) begin
      first_strobe[l] = -1; first_active[l] = -1; first_valid[l] = -1;
    end
  endtask

  task automatic run_stream();
    int maxlen;
    logic [1:0] b2;
    logic [3:0] b4;
    maxlen = 0;
    for (int l = 0; l < 6; l++) if (len[l] > maxlen) maxlen = len[l];
    for (int p = 0; p < maxlen; p++) begin
      for (int l = 0; l < 2; l++) b2[l] = (p < len[l]) ? bits_mem[l][p] : 1'b0;
      for (int l = 0; l < 4; l++) b4[l] = (p < len[l+2]) ? bits_mem[l+2][p] : 1'b0;
      step(b2, b4);
      ecount++;
      for (int l = 0; l < 2; l++) begin
        if (symbol_strobe[l] && first_strobe[l] < 0) first_strobe[l] = ecount;
        if (active[l]        && first_active[l] < 0) first_active[l] = ecount;
        if (valid_out[l]     && first_valid[l]  < 0) first_valid[l]  = ecount;
      end
    end
    for (int l = 0; l < 6; l++) len[l] = 0;
  endtask

  task automatic send2(input logic [7:0] s0, input logic [7:0] s1);
    push_sym(0, {8'd0, s0}, 8);
    push_sym(1, {8'd0, s1}, 8);
    run_stream();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    tbl[0] = '{8'hBC, 8'hBC, 16'h0000, 2'b00, 2'b00};
    tbl[1] = '{8'hBC, 8'hBC, 16'h0000, 2'b00, 2'b00};
    tbl[2] = '{8'hBC, 8'hBC, 16'h0000, 2'b00, 2'b00};
    tbl[3] = '{8'hBC, 8'hBC, 16'h0000, 2'b00, 2'b11};
    tbl[4] = '{8'h11, 8'h11, 16'h1111, 2'b11, 2'b11};
    tbl[5] = '{8'h22, 8'h22, 16'h2222, 2'b11, 2'b11};
    tbl[6] = '{8'h7C, 8'h7C, 16'h7C7C, 2'b00, 2'b11};
    tbl[7] = '{8'hBC, 8'hA5, 16'hA5BC, 2'b10, 2'b11};
    tbl[8] = '{8'h33, 8'h7C, 16'h7C33, 2'b01, 2'b11};

    for (int l = 0; l < 6; l++) len[l] = 0;
    reset = 1'b1;
    data_serial  = '0;
    data_serial4 = '0;
    models_reset();
    #12;
    check("reset_state", {data_paralelo, valid_out, active, symbol_strobe}, '0);
    check("reset_state4", {data_paralelo4, valid_out4, active4, symbol_strobe4}, '0);
    do_reset();

    // Aligned lock and data/idle/COM filtering.
    for (int k = 0; k < 9; k++) begin
      send2(tbl[k].sym0, tbl[k].sym1);
      check($sformatf("tbl_data[%0d]", k), data_paralelo, tbl[k].exp_data);
      check($sformatf("tbl_valid[%0d]", k), valid_out, tbl[k].exp_valid);
      check($sformatf("tbl_active[%0d]", k), active, tbl[k].exp_active);
    end

    // Lane 1 delayed 3 bits relative to lane 0.
    do_reset();
    clear_events();
    push_zeros(1, 3);
    for (int k = 0; k < 4; k++) begin
      push_sym(0, 16'hBC, 8); push_sym(1, 16'hBC, 8);
    end
    push_sym(0, 16'h11, 8); push_sym(1, 16'h11, 8);
    push_sym(0, 16'h22, 8); push_sym(1, 16'h22, 8);
    run_stream();
    check("offset_strobe0", first_strobe[0], 8);
    check("offset_strobe1", first_strobe[1], 11);
    check("offset_active0", first_active[0], 32);
    check("offset_active1", first_active[1], 35);
    check("offset_valid0", first_valid[0], 40);
    check("offset_valid1", first_valid[1], 43);
    check("offset_data", data_paralelo, 16'h2222);

    // False lock: BC,BC,55 must fall back to hunting.
    do_reset();
    clear_events();
    push_sym(0, 16'hBC, 8); push_sym(0, 16'hBC, 8); push_sym(0, 16'h55, 8);
    for (int k = 0; k < 3; k++) push_sym(0, 16'hBC, 8);
    run_stream();
    check("false_lock_inactive", active[0], 1'b0);
    push_sym(0, 16'hBC, 8);
    run_stream();
    check("false_lock_relock", active[0], 1'b1);
    check("false_lock_edge", first_active[0], 56);

    // Asynchronous reset between edges while lane 0 is active with data.
    push_sym(0, 16'h11, 8);
    run_stream();
    check("pre_reset_valid", valid_out[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_out", {data_paralelo, valid_out, active, symbol_strobe}, '0);
    models_reset();
    data_serial = '0;
    @(negedge clk_32f);
    reset = 1'b0;
    clear_events();
    for (int k = 0; k < 4; k++) push_sym(0, 16'hBC, 8);
    run_stream();
    check("rehunt_active", active[0], 1'b1);
    check("rehunt_edge", first_active[0], 32);

    // All-zero / all-one runs after lock.
    do_reset();
    for (int k = 0; k < 4; k++) send2(8'hBC, 8'hBC);
    for (int k = 0; k < 3; k++) send2(8'h00, 8'h00);
    check("los3_active", active, 2'b11);
    send2(8'h00, 8'h00);
`ifdef LOS_DETECT_EN
    check("los4_active", active, 2'b00);
    check("los4_valid", valid_out, 2'b00);
`else
    check("los4_active", active, 2'b11);
    check("los4_valid", valid_out, 2'b11);
`endif
    for (int k = 0; k < 4; k++) send2(8'hBC, 8'hBC);
    send2(8'h00, 8'h00); send2(8'h00, 8'h00); send2(8'hA5, 8'hA5); send2(8'h00, 8'h00);
    check("los_broken_active", active, 2'b11);
    send2(8'hA5, 8'hA5);
    send2(8'hFF, 8'hFF); send2(8'hFF, 8'hFF); send2(8'hFF, 8'hFF); send2(8'h00, 8'h00);
`ifdef LOS_DETECT_EN
    check("los_mix_active", active, 2'b00);
    check("los_mix_hold", data_paralelo, 16'hFFFF);
`else
    check("los_mix_active", active, 2'b11);
    check("los_mix_data", data_paralelo, 16'h0000);
`endif

    // Four 10-bit lanes at different bit offsets.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_zeros(i + 2, i);
      for (int k = 0; k < 4; k++) push_sym(i + 2, 16'h17C, 10);
      push_sym(i + 2, 16'h2A5 + 16'(i), 10);
    end
    run_stream();
    check("sweep_active", active4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sweep_data[%0d]", i), data_paralelo4[i*10 +: 10], 10'h2A5 + 10'(i));
      check($sformatf("sweep_valid[%0d]", i), valid_out4[i], 1'b1);
    end

    // Randomized streams against the model.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int l = 0; l < 6; l++) begin
        int w;
        logic [15:0] com, mask, sym;
        int r;
        w    = (l < 2) ? 8 : 10;
        com  = (l < 2) ? 16'h00BC : 16'h017C;
        mask = 16'((32'd1 << w) - 1);
        for (int k = 0; k < int'($urandom_range(0, w - 1)); k++) push_bit(l, 1'($urandom));
        for (int k = 0; k < 5; k++) push_sym(l, com, w);
        for (int k = 0; k < 18; k++) begin
          r = int'($urandom_range(0, 99));
          if (r < 50)      sym = 16'($urandom) & mask;
          else if (r < 65) sym = 16'h007C;
          else if (r < 80) sym = com;
          else if (r < 90) sym = 16'h0000;
          else             sym = mask;
          push_sym(l, sym, w);
          if ($urandom_range(0, 19) == 0) push_bit(l, 1'($urandom));
        end
      end
      run_stream();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
